// File: rtl/seg_scan_if.sv
// Bundle between the score tracker side and the digit scan controller.
//   en, bcd_ones, bcd_tens, game_over, lz_blank : driven toward the controller
//   digit_out, dig_en, slot_tick, flash_phase   : driven by the controller
// master: score/display owner side, slave: seg_scan_controller.
interface seg_scan_if;
    logic       en;
    logic [3:0] bcd_ones;
    logic [3:0] bcd_tens;
    logic       game_over;
    logic       lz_blank;
    logic [3:0] digit_out;
    logic [1:0] dig_en;
    logic       slot_tick;
    logic       flash_phase;

    modport master (
        output en, bcd_ones, bcd_tens, game_over, lz_blank,
        input  digit_out, dig_en, slot_tick, flash_phase
    );

    modport slave (
        input  en, bcd_ones, bcd_tens, game_over, lz_blank,
        output digit_out, dig_en, slot_tick, flash_phase
    );
endinterface

// File: rtl/seg_scan_controller.sv
// Two-digit seven-segment scan controller. Time-multiplexes the ones and
// tens BCD digits onto one shared decoder with per-slot dead time,
// optional tens leading-zero suppression and a game-over flash.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : seg_scan_if.slave
//          in : en, bcd_ones, bcd_tens, game_over, lz_blank
//          out: digit_out, dig_en (bit0 ones, bit1 tens), slot_tick,
//               flash_phase (1 = blanked)
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | scan disabled, display blank, counters cleared
// ONES  | ones digit slot, SCAN_DIV cycles, shadow captured on entry
// TENS  | tens digit slot, SCAN_DIV cycles, uses shadow from ONES
module seg_scan_controller #(
    parameter int SCAN_DIV    = 1000,
    parameter int DEAD_CYCLES = 2,
    parameter int FLASH_SLOTS = 256
) (
    input  logic     clk,
    input  logic     rst,
    seg_scan_if.slave bus
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int FW = (FLASH_SLOTS > 1) ? $clog2(FLASH_SLOTS) : 1;
    localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEAD_N     = DW'(DEAD_CYCLES);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_SLOTS - 1);

    typedef enum logic [1:0] {IDLE, ONES, TENS} state_t;

    state_t        state, state_nx;
    logic [DW-1:0] div_cnt, div_nx;
    logic [FW-1:0] flash_cnt, flash_nx;
    logic          phase, phase_nx;
    logic [3:0]    sh_ones, sh_ones_nx;
    logic [3:0]    sh_tens, sh_tens_nx;
    logic          sh_lz, sh_lz_nx;
    logic [3:0]    digit_q, digit_nx;
    logic [1:0]    dig_en_q, dig_en_nx;
    logic          tick_q, tick_nx;
    logic          tick_now;
    logic          capture;
    logic          blank_nx;

    // Outputs are registered from the next-state values so each output
    // register holds exactly the function of the state registers it sits
    // beside, with no path from the inputs.
    always_comb begin
        state_nx   = state;
        div_nx     = div_cnt;
        flash_nx   = flash_cnt;
        phase_nx   = phase;
        sh_ones_nx = sh_ones;
        sh_tens_nx = sh_tens;
        sh_lz_nx   = sh_lz;
        capture    = 1'b0;
        tick_now   = (state != IDLE) && (div_cnt == DIV_LAST);

        if (!bus.en) begin
            state_nx = IDLE;
            div_nx   = '0;
            flash_nx = '0;
            phase_nx = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = ONES;
                    div_nx   = '0;
                    capture  = 1'b1;
                end
                ONES: begin
                    if (tick_now) begin
                        state_nx = TENS;
                        div_nx   = '0;
                    end else begin
                        div_nx = div_cnt + 1'b1;
                    end
                end
                TENS: begin
                    if (tick_now) begin
                        state_nx = ONES;
                        div_nx   = '0;
                        capture  = 1'b1;
                    end else begin
                        div_nx = div_cnt + 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    div_nx   = '0;
                end
            endcase

            // Both digits and the suppression flag are latched together so
            // the ONES/TENS pair that follows always shows one score.
            if (capture) begin
                sh_ones_nx = bus.bcd_ones;
                sh_tens_nx = bus.bcd_tens;
                sh_lz_nx   = bus.lz_blank;
            end

            // Clearing takes priority over a toggle on the same tick.
            if (!bus.game_over) begin
                flash_nx = '0;
                phase_nx = 1'b0;
            end else if (tick_now) begin
                if (flash_cnt == FLASH_LAST) begin
                    flash_nx = '0;
                    phase_nx = ~phase;
                end else begin
                    flash_nx = flash_cnt + 1'b1;
                end
            end
        end

        case (state_nx)
            ONES:    digit_nx = sh_ones_nx;
            TENS:    digit_nx = sh_tens_nx;
            default: digit_nx = 4'd0;
        endcase

        blank_nx = (state_nx == IDLE) || (div_nx < DEAD_N) || phase_nx ||
                   ((state_nx == TENS) && sh_lz_nx && (sh_tens_nx == 4'd0));

        if (blank_nx)
            dig_en_nx = 2'b00;
        else if (state_nx == ONES)
            dig_en_nx = 2'b01;
        else
            dig_en_nx = 2'b10;

        tick_nx = (state_nx != IDLE) && (div_nx == DIV_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            flash_cnt <= '0;
            phase     <= 1'b0;
            sh_ones   <= 4'd0;
            sh_tens   <= 4'd0;
            sh_lz     <= 1'b0;
            digit_q   <= 4'd0;
            dig_en_q  <= 2'b00;
            tick_q    <= 1'b0;
        end else begin
            state     <= state_nx;
            div_cnt   <= div_nx;
            flash_cnt <= flash_nx;
            phase     <= phase_nx;
            sh_ones   <= sh_ones_nx;
            sh_tens   <= sh_tens_nx;
            sh_lz     <= sh_lz_nx;
            digit_q   <= digit_nx;
            dig_en_q  <= dig_en_nx;
            tick_q    <= tick_nx;
        end
    end

    assign bus.digit_out   = digit_q;
    assign bus.dig_en      = dig_en_q;
    assign bus.slot_tick   = tick_q;
    assign bus.flash_phase = phase;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller with SCAN_DIV=8, DEAD_CYCLES=2, FLASH_SLOTS=2.
// Stimulus pushes expected per-cycle outputs (stamped with a cycle index)
// into a queue; a negedge monitor pops and compares them.
module tb_seg_scan_controller;
    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    seg_scan_if bus ();

    seg_scan_controller #(
        .SCAN_DIV   (8),
        .DEAD_CYCLES(2),
        .FLASH_SLOTS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int         c;
        logic [3:0] d;
        logic [1:0] e;
        logic       t;
        logic       p;
        string      tag;
    } exp_t;

    exp_t q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].c <= cyc) begin
            exp_t x;
            x = q.pop_front();
            n_cmp++;
            if (x.c < cyc) begin
                n_bad++;
                $display("FAIL %s: expectation for cycle %0d not reached before cycle %0d", x.tag, x.c, cyc);
            end else if (bus.digit_out !== x.d || bus.dig_en !== x.e ||
                         bus.slot_tick !== x.t || bus.flash_phase !== x.p) begin
                n_bad++;
                $display("FAIL %s cyc=%0d: got digit=%0d en=%b tick=%b ph=%b, expected digit=%0d en=%b tick=%b ph=%b",
                         x.tag, cyc, bus.digit_out, bus.dig_en, bus.slot_tick, bus.flash_phase,
                         x.d, x.e, x.t, x.p);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic exp1(input int c, input logic [3:0] d, input logic [1:0] e,
                        input logic t, input logic p, input string tag);
        exp_t x;
        x.c = c; x.d = d; x.e = e; x.t = t; x.p = p; x.tag = tag;
        q.push_back(x);
    endtask

    // Cycles first..last of a slot beginning at c0; vis=0 means blanked.
    task automatic exp_range(input int c0, input int first, input int last,
                             input bit tens, input logic [3:0] d, input bit vis,
                             input logic p, input string tag);
        for (int i = first; i <= last; i++) begin
            logic [1:0] e;
            if (!vis || i < 2) e = 2'b00;
            else if (tens)     e = 2'b10;
            else               e = 2'b01;
            exp1(c0 + i, d, e, (i == 7), p, tag);
        end
    endtask

    task automatic exp_slot(input int c0, input bit tens, input logic [3:0] d,
                            input bit vis, input logic p, input string tag);
        exp_range(c0, 0, 7, tens, d, vis, p, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        cyc = 0; n_cmp = 0; n_bad = 0;
        rst = 1'b1;
        bus.en = 1'b0; bus.bcd_ones = 4'd0; bus.bcd_tens = 4'd0;
        bus.game_over = 1'b0; bus.lz_blank = 1'b0;

        tick();
        exp1(cyc, 4'd0, 2'b00, 1'b0, 1'b0, "reset");
        rst = 1'b0;
        tick();
        exp1(cyc, 4'd0, 2'b00, 1'b0, 1'b0, "idle");

        // basic scan + coherency
        bus.bcd_ones = 4'd7; bus.bcd_tens = 4'd4; bus.en = 1'b1;
        s = cyc + 1;
        exp_slot(s,      0, 4'd7, 1, 0, "basic_ones");
        exp_slot(s + 8,  1, 4'd4, 1, 0, "basic_tens");
        exp_slot(s + 16, 0, 4'd7, 1, 0, "coh_ones_old");
        exp_slot(s + 24, 1, 4'd4, 1, 0, "coh_tens_old");
        exp_slot(s + 32, 0, 4'd8, 1, 0, "coh_ones_new");
        exp_slot(s + 40, 1, 4'd5, 1, 0, "coh_tens_new");
        wait_until(s + 19);
        bus.bcd_ones = 4'd8; bus.bcd_tens = 4'd5;

        // leading zero
        exp_slot(s + 48, 0, 4'd8, 1, 0, "lz_prev_ones");
        exp_slot(s + 56, 1, 4'd5, 1, 0, "lz_prev_tens");
        exp_slot(s + 64, 0, 4'd3, 1, 0, "lz_ones");
        exp_slot(s + 72, 1, 4'd0, 0, 0, "lz_tens_blank");
        exp_slot(s + 80, 0, 4'd3, 1, 0, "nolz_ones");
        exp_slot(s + 88, 1, 4'd0, 1, 0, "nolz_tens_zero");
        wait_until(s + 50);
        bus.bcd_ones = 4'd3; bus.bcd_tens = 4'd0; bus.lz_blank = 1'b1;
        wait_until(s + 66);
        bus.lz_blank = 1'b0;

        // flash
        exp_slot(s + 96,  0, 4'd3, 1, 0, "flash_ones_p0");
        exp_slot(s + 104, 1, 4'd0, 1, 0, "flash_tens_p0");
        exp_slot(s + 112, 0, 4'd3, 0, 1, "flash_ones_p1");
        exp_slot(s + 120, 1, 4'd0, 0, 1, "flash_tens_p1");
        exp_slot(s + 128, 0, 4'd3, 1, 0, "flash_ones_p0b");
        exp_slot(s + 136, 1, 4'd0, 1, 0, "flash_tens_p0b");
        exp_range(s + 144, 0, 3, 0, 4'd3, 0, 1, "flash_p1_before_clear");
        exp_range(s + 144, 4, 7, 0, 4'd3, 1, 0, "flash_cleared");
        wait_until(s + 98);
        bus.game_over = 1'b1;
        wait_until(s + 147);
        bus.game_over = 1'b0;

        // enable drop
        exp_range(s + 152, 0, 5, 1, 4'd0, 1, 0, "drop_tens");
        for (int c = s + 158; c <= s + 160; c++)
            exp1(c, 4'd0, 2'b00, 1'b0, 1'b0, "drop_idle");
        exp_slot(s + 161, 0, 4'd1, 1, 0, "restart_ones");
        exp_slot(s + 169, 1, 4'd2, 1, 0, "restart_tens");
        wait_until(s + 157);
        bus.en = 1'b0;
        tick();
        bus.bcd_ones = 4'd1; bus.bcd_tens = 4'd2;
        wait_until(s + 160);
        bus.en = 1'b1;

        // reset while flashing
        exp_slot(s + 177, 0, 4'd1, 0, 1, "pre_rst_ones_p1");
        exp_range(s + 185, 0, 3, 1, 4'd2, 0, 1, "pre_rst_tens_p1");
        exp1(s + 189, 4'd0, 2'b00, 1'b0, 1'b0, "async_rst");
        exp1(s + 190, 4'd0, 2'b00, 1'b0, 1'b0, "rst_held");
        exp_slot(s + 191, 0, 4'd1, 1, 0, "post_rst_ones");
        exp_slot(s + 199, 1, 4'd2, 1, 0, "post_rst_tens");
        wait_until(s + 162);
        bus.game_over = 1'b1;
        wait_until(s + 189);
        #2;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        wait_until(s + 208);
        bus.en = 1'b0;
        tick();
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
